// File: rtl/axi_read_rr_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
// Holds the AR state encoding and the AXI ID width.
package axi_read_rr_arbiter_pkg;

   localparam int AXI_ID_WIDTH = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ADDR = 1'b1
   } ar_state_e;

   // every master index must be expressible as an ARID
   function automatic bit masters_fit(input int masters);
      return (masters >= 2) && (masters <= (2 ** AXI_ID_WIDTH));
   endfunction

endpackage

// File: rtl/axi_read_rr_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr, wrapping at N.
module rr_picker #(
   parameter int N  = 9,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          found
);

   // scan N slots starting at ptr, first hit wins
   always_comb begin
      logic [IW:0] idx;
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr} + (IW+1)'(i);
         if (idx >= (IW+1)'(N))
            idx = idx - (IW+1)'(N);
         if (!found && req[idx[IW-1:0]]) begin
            found = 1'b1;
            grant = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/axi_read_rr_arbiter.sv
// Round-robin AXI read arbiter: one burst per master, ARID = index.
// R beats are steered back to the owning master by RID.
module axi_read_rr_arbiter
   import axi_read_rr_arbiter_pkg::*;
#(
   parameter int MASTERS    = 9,
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_OUT    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [MASTERS-1:0]            m_arvalid,
   output logic [MASTERS-1:0]            m_arready,
   input  logic [MASTERS*ADDR_WIDTH-1:0] m_araddr,
   input  logic [MASTERS*4-1:0]          m_arlen,
   output logic [MASTERS-1:0]            m_rvalid,
   output logic [MASTERS-1:0]            m_rlast,
   output logic [DATA_WIDTH-1:0]         m_rdata,
   input  logic [MASTERS-1:0]            m_rready,
   output logic                          ARVALID,
   input  logic                          ARREADY,
   output logic [AXI_ID_WIDTH-1:0]       ARID,
   output logic [3:0]                    ARLEN,
   output logic [ADDR_WIDTH-1:0]         ARADDR,
   input  logic                          RVALID,
   output logic                          RREADY,
   input  logic                          RLAST,
   input  logic [AXI_ID_WIDTH-1:0]       RID,
   input  logic [DATA_WIDTH-1:0]         RDATA,
   output logic [MASTERS-1:0]            busy,
   output logic                          id_err
);

   localparam int IW  = $clog2(MASTERS);
   localparam int OW  = $clog2(MAX_OUT + 1);
   localparam int IDN = 2 ** AXI_ID_WIDTH;

   if (!masters_fit(MASTERS)) begin : g_bad_masters
      $error("MASTERS does not fit in the AXI ID space");
   end

   ar_state_e               state;
   logic [IW-1:0]           ptr;
   logic [IW-1:0]           gnt_q;
   logic [IW-1:0]           pick;
   logic                    found;
   logic [MASTERS-1:0]      busy_q;
   logic [OW-1:0]           outst;
   logic [ADDR_WIDTH-1:0]   araddr_q;
   logic [3:0]              arlen_q;
   logic                    id_err_q;
   logic                    ar_hs;
   logic                    can_grant;
   logic                    rid_ok;
   logic                    r_done;
   logic [IDN-1:0]          busy_ext;
   logic [IDN-1:0]          rready_ext;

   rr_picker #(
      .N  (MASTERS),
      .IW (IW)
   ) u_pick (
      .req   (m_arvalid & ~busy_q),
      .ptr   (ptr),
      .grant (pick),
      .found (found)
   );

   assign can_grant = outst < OW'(MAX_OUT);
   assign ARVALID   = (state == ADDR);
   assign ar_hs     = ARVALID && ARREADY;
   assign ARID      = AXI_ID_WIDTH'(gnt_q);
   assign ARADDR    = araddr_q;
   assign ARLEN     = arlen_q;
   assign busy      = busy_q;
   assign id_err    = id_err_q;

   // RID is only trusted when it names a master with a live burst
   assign busy_ext   = IDN'(busy_q);
   assign rready_ext = IDN'(m_rready);
   assign rid_ok     = busy_ext[RID];
   assign RREADY     = rid_ok ? rready_ext[RID] : 1'b1;
   assign r_done     = rid_ok && RVALID && RREADY && RLAST;
   assign m_rdata    = RDATA;

   // per-master acceptance pulse and R steering
   always_comb begin
      for (int i = 0; i < MASTERS; i++) begin
         m_arready[i] = ar_hs && (gnt_q == IW'(i));
         m_rvalid[i]  = rid_ok && RVALID &&
                        (RID == AXI_ID_WIDTH'(i));
         m_rlast[i]   = rid_ok && RVALID && RLAST &&
                        (RID == AXI_ID_WIDTH'(i));
      end
   end

   // AR FSM: pick a winner in IDLE, hold the request in ADDR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt_q    <= '0;
         araddr_q <= '0;
         arlen_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found && can_grant) begin
                  state    <= ADDR;
                  gnt_q    <= pick;
                  araddr_q <= m_araddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                  arlen_q  <= m_arlen[int'(pick)*4 +: 4];
               end
            end
            ADDR: begin
               if (ARREADY)
                  state <= IDLE;
            end
         endcase
      end
   end

   // burst tracking: busy bits, outstanding count, rr pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         outst  <= '0;
         ptr    <= '0;
      end else begin
         for (int i = 0; i < MASTERS; i++) begin
            if (ar_hs && (gnt_q == IW'(i)))
               busy_q[i] <= 1'b1;
            else if (r_done && (RID == AXI_ID_WIDTH'(i)))
               busy_q[i] <= 1'b0;
         end
         unique case ({ar_hs, r_done})
            2'b10:   outst <= outst + OW'(1);
            2'b01:   outst <= outst - OW'(1);
            default: outst <= outst;
         endcase
         if (ar_hs)
            ptr <= (gnt_q == IW'(MASTERS-1)) ? '0 : gnt_q + IW'(1);
      end
   end

   // sticky flag for beats nobody owns
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         id_err_q <= 1'b0;
      else if (RVALID && !rid_ok)
         id_err_q <= 1'b1;
   end

endmodule

// File: tb/tb_axi_read_rr_arbiter.sv
// Directed bench for axi_read_rr_arbiter.
// AR and R expectations flow through queues and are checked on handshake.
module tb_axi_read_rr_arbiter;

   localparam int M  = 9;
   localparam int AW = 26;
   localparam int DW = 32;
   localparam int MO = 4;

   typedef struct {
      int          id;
      logic [AW-1:0] addr;
      logic [3:0]  len;
   } ar_exp_t;

   typedef struct {
      logic [M-1:0]  vld;
      logic [M-1:0]  last;
      logic [DW-1:0] data;
   } r_exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [M-1:0]    m_arvalid = '0;
   logic [M-1:0]    m_arready;
   logic [M*AW-1:0] m_araddr = '0;
   logic [M*4-1:0]  m_arlen = '0;
   logic [M-1:0]    m_rvalid;
   logic [M-1:0]    m_rlast;
   logic [DW-1:0]   m_rdata;
   logic [M-1:0]    m_rready = '0;
   logic            ARVALID;
   logic            ARREADY = 1'b0;
   logic [3:0]      ARID;
   logic [3:0]      ARLEN;
   logic [AW-1:0]   ARADDR;
   logic            RVALID = 1'b0;
   logic            RREADY;
   logic            RLAST = 1'b0;
   logic [3:0]      RID = '0;
   logic [DW-1:0]   RDATA = '0;
   logic [M-1:0]    busy;
   logic            id_err;

   int n_cmp = 0;
   int n_mis = 0;
   ar_exp_t ar_q[$];
   r_exp_t  r_q[$];
   logic [M-1:0] mdl_busy = '0;

   axi_read_rr_arbiter #(
      .MASTERS    (M),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MAX_OUT    (MO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_araddr  (m_araddr),
      .m_arlen   (m_arlen),
      .m_rvalid  (m_rvalid),
      .m_rlast   (m_rlast),
      .m_rdata   (m_rdata),
      .m_rready  (m_rready),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .ARID      (ARID),
      .ARLEN     (ARLEN),
      .ARADDR    (ARADDR),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .RLAST     (RLAST),
      .RID       (RID),
      .RDATA     (RDATA),
      .busy      (busy),
      .id_err    (id_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] addr_of(input int i);
      return AW'(32'h1000 + i * 32'h40);
   endfunction

   task automatic req(input int i, input logic [AW-1:0] a,
                      input logic [3:0] l);
      m_arvalid[i] = 1'b1;
      m_araddr[i*AW +: AW] = a;
      m_arlen[i*4 +: 4] = l;
   endtask

   task automatic exp_ar(input int i, input logic [AW-1:0] a,
                         input logic [3:0] l);
      ar_exp_t e;
      e.id = i;
      e.addr = a;
      e.len = l;
      ar_q.push_back(e);
   endtask

   task automatic wait_ar(input int budget, input bit drop,
                          output int waited);
      ar_exp_t e;
      waited = 0;
      #1;
      while (!(ARVALID && ARREADY) && waited < budget) begin
         tick();
         waited++;
      end
      chk("ar_handshake", 64'(ARVALID && ARREADY), 64'd1);
      if (!(ARVALID && ARREADY) || ar_q.size() == 0) return;
      e = ar_q.pop_front();
      chk("arid", 64'(ARID), 64'(e.id));
      chk("araddr", 64'(ARADDR), 64'(e.addr));
      chk("arlen", 64'(ARLEN), 64'(e.len));
      chk("m_arready", 64'(m_arready), 64'(1) << e.id);
      tick();
      if (drop) m_arvalid[e.id] = 1'b0;
      mdl_busy[e.id] = 1'b1;
      chk("busy_after_ar", 64'(busy), 64'(mdl_busy));
      chk("m_arready_pulse", 64'(m_arready), 64'd0);
   endtask

   task automatic beat(input int id, input logic [DW-1:0] d,
                       input logic last, input int stall);
      r_exp_t e;
      e.vld  = M'(1) << id;
      e.last = last ? e.vld : '0;
      e.data = d;
      r_q.push_back(e);
      RVALID = 1'b1;
      RID = 4'(id);
      RDATA = d;
      RLAST = last;
      m_rready = '0;
      for (int c = 0; c <= stall; c++) begin
         m_rready[id] = (c == stall);
         #1;
         if (c < stall) begin
            chk("rready_stall", 64'(RREADY), 64'd0);
            chk("rvalid_stall", 64'(m_rvalid), 64'(e.vld));
            tick();
         end
      end
      e = r_q.pop_front();
      chk("rready", 64'(RREADY), 64'd1);
      chk("m_rvalid", 64'(m_rvalid), 64'(e.vld));
      chk("m_rlast", 64'(m_rlast), 64'(e.last));
      chk("m_rdata", 64'(m_rdata), 64'(e.data));
      tick();
      RVALID = 1'b0;
      RLAST = 1'b0;
      m_rready = '0;
      if (last) mdl_busy[id] = 1'b0;
      chk("busy_after_beat", 64'(busy), 64'(mdl_busy));
   endtask

   task automatic bad_beat(input int id);
      RVALID = 1'b1;
      RID = 4'(id);
      RDATA = 32'hDEAD_0000 + 32'(id);
      RLAST = 1'b1;
      m_rready = '0;
      #1;
      chk("bad_rready", 64'(RREADY), 64'd1);
      chk("bad_rvalid", 64'(m_rvalid), 64'd0);
      chk("bad_rlast", 64'(m_rlast), 64'd0);
      tick();
      RVALID = 1'b0;
      RLAST = 1'b0;
      chk("id_err_set", 64'(id_err), 64'd1);
      chk("bad_busy", 64'(busy), 64'(mdl_busy));
   endtask

   initial begin
      int n;
      #1 rst = 1'b1;
      #2;
      chk("rst_arvalid", 64'(ARVALID), 64'd0);
      chk("rst_arid", 64'(ARID), 64'd0);
      chk("rst_araddr", 64'(ARADDR), 64'd0);
      chk("rst_arlen", 64'(ARLEN), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_id_err", 64'(id_err), 64'd0);
      chk("rst_m_arready", 64'(m_arready), 64'd0);
      chk("rst_rready", 64'(RREADY), 64'd1);
      #9 rst = 1'b0;
      tick();

      // single request: master 3, 4-beat burst
      ARREADY = 1'b1;
      req(3, 26'h100, 4'd3);
      exp_ar(3, 26'h100, 4'd3);
      wait_ar(4, 1'b1, n);
      chk("ar_latency", 64'(n), 64'd1);
      for (int k = 0; k < 4; k++)
         beat(3, 32'hC0DE_0000 + 32'(k), k == 3, 0);
      chk("single_done", 64'(busy), 64'd0);

      // round robin from ptr 0 with masters 0, 1, 8
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      req(0, addr_of(0), 4'd0);
      req(1, addr_of(1), 4'd1);
      req(8, addr_of(8), 4'd8);
      exp_ar(0, addr_of(0), 4'd0);
      exp_ar(1, addr_of(1), 4'd1);
      exp_ar(8, addr_of(8), 4'd8);
      wait_ar(4, 1'b0, n);
      wait_ar(4, 1'b0, n);
      wait_ar(4, 1'b0, n);
      tick();
      chk("rr_all_busy", 64'(ARVALID), 64'd0);
      beat(0, 32'h0000_0055, 1'b1, 0);
      exp_ar(0, addr_of(0), 4'd0);
      wait_ar(4, 1'b0, n);
      m_arvalid = '0;
      beat(1, 32'h0000_0011, 1'b1, 0);
      beat(8, 32'h0000_0088, 1'b1, 0);
      beat(0, 32'h0000_0000, 1'b1, 0);

      // saturation: six requesters, ptr at 1
      for (int i = 2; i < 8; i++) req(i, addr_of(i), 4'(i));
      for (int i = 2; i < 6; i++) exp_ar(i, addr_of(i), 4'(i));
      for (int i = 0; i < 4; i++) wait_ar(4, 1'b0, n);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sat_hold", 64'(ARVALID), 64'd0);
      end
      beat(3, 32'h0000_0033, 1'b1, 0);
      exp_ar(6, addr_of(6), 4'd6);
      wait_ar(2, 1'b0, n);
      chk("sat_resume", 64'(n <= 2), 64'd1);
      m_arvalid = '0;
      beat(2, 32'h2, 1'b1, 0);
      beat(4, 32'h4, 1'b1, 0);
      beat(5, 32'h5, 1'b1, 0);
      beat(6, 32'h6, 1'b1, 0);

      // AR backpressure, master drops request mid-wait
      ARREADY = 1'b0;
      req(5, 26'h2A0, 4'd7);
      exp_ar(5, 26'h2A0, 4'd7);
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("bp_arvalid", 64'(ARVALID), 64'd1);
         chk("bp_arid", 64'(ARID), 64'(ar_q[0].id));
         chk("bp_araddr", 64'(ARADDR), 64'(ar_q[0].addr));
         chk("bp_arlen", 64'(ARLEN), 64'(ar_q[0].len));
         chk("bp_m_arready", 64'(m_arready), 64'd0);
         if (c == 3) m_arvalid[5] = 1'b0;
         tick();
      end
      ARREADY = 1'b1;
      wait_ar(1, 1'b1, n);

      // interleaved beats for 2 and 5 with a stall on 5
      req(2, addr_of(2), 4'd1);
      exp_ar(2, addr_of(2), 4'd1);
      wait_ar(3, 1'b1, n);
      beat(2, 32'hA000_0000, 1'b0, 0);
      beat(5, 32'hB000_0001, 1'b0, 2);
      beat(2, 32'hA000_0002, 1'b1, 0);
      beat(5, 32'hB000_0003, 1'b1, 0);

      // unowned beats, reset mid-burst, stale beats
      chk("id_err_clean", 64'(id_err), 64'd0);
      bad_beat(0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("id_err_cleared", 64'(id_err), 64'd0);
      bad_beat(12);
      req(4, addr_of(4), 4'd2);
      exp_ar(4, addr_of(4), 4'd2);
      wait_ar(3, 1'b1, n);
      ARREADY = 1'b0;
      req(6, addr_of(6), 4'd0);
      tick();
      chk("pre_rst_arvalid", 64'(ARVALID), 64'd1);
      #2 rst = 1'b1;
      #1;
      mdl_busy = '0;
      m_arvalid = '0;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_arvalid", 64'(ARVALID), 64'd0);
      chk("arst_m_arready", 64'(m_arready), 64'd0);
      chk("arst_id_err", 64'(id_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      bad_beat(4);

      // outstanding restarts at zero: exactly four grants
      ARREADY = 1'b1;
      for (int i = 0; i < 5; i++) req(i, addr_of(i), 4'(i));
      for (int i = 0; i < 4; i++) exp_ar(i, addr_of(i), 4'(i));
      for (int i = 0; i < 4; i++) wait_ar(4, 1'b1, n);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_cap", 64'(ARVALID), 64'd0);
      end
      m_arvalid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/axi_read_rr_arbiter.md
# axi_read_rr_arbiter

Round-robin read-channel arbiter that shares the single core AXI read port among the instruction-cache refill masters and the data-cache read master. Each master issues one burst at a time and gets its master index as ARID. Returning R beats are steered back to the owner by RID. Sits between the cache read masters and the top-level AXI AR/R pins, as a read-only companion to the write path.

## Interface
Parameters:
- MASTERS, 9, number of read masters (2..16)
- ADDR_WIDTH, 26, byte address width
- DATA_WIDTH, 32, beat width
- MAX_OUT, 4, maximum bursts outstanding on AXI (1..MASTERS)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- m_arvalid  in  MASTERS  per-master request; must be held until m_arready
- m_arready  out  MASTERS  one-cycle acceptance pulse to master i
- m_araddr  in  MASTERS*ADDR_WIDTH  per-master burst address, master i at slice i
- m_arlen  in  MASTERS*4  per-master AXI length (beats-1)
- m_rvalid  out  MASTERS  beat valid for master i
- m_rlast  out  MASTERS  last beat for master i
- m_rdata  out  DATA_WIDTH  RDATA broadcast to all masters
- m_rready  in  MASTERS  per-master beat accept
- ARVALID  out  1; ARREADY  in  1; ARID  out  4; ARLEN  out  4; ARADDR  out  ADDR_WIDTH
- RVALID  in  1; RREADY  out  1; RLAST  in  1; RID  in  4; RDATA  in  DATA_WIDTH
- busy  out  MASTERS  master i has a burst outstanding
- id_err  out  1  sticky: a beat arrived with an RID that is out of range or not busy

## Operation
- AR FSM has two states: IDLE and ADDR.
- IDLE: the eligible set is m_arvalid & ~busy. A grant is allowed only when outstanding < MAX_OUT. The winner is the first eligible index at or after ptr, with wrap.
  - On a win, the FSM registers ARID=g, ARADDR and ARLEN from slice g, stores g, and moves to ADDR.
  - With no winner, it stays in IDLE.
- ADDR: ARVALID=1, and the registered fields are held stable.
  - On ARVALID&&ARREADY: m_arready[g]=1 combinationally that cycle, busy[g]<=1, outstanding++, ptr<=(g+1) mod MASTERS, state<=IDLE.
- R routing is combinational:
  - When RID<MASTERS and busy[RID]: m_rvalid[RID]=RVALID, m_rlast[RID]=RLAST, RREADY=m_rready[RID]. All other m_rvalid/m_rlast are 0.
  - Otherwise: all m_rvalid=0 and RREADY=1, so the beat is drained. If RVALID is high, id_err<=1.
- A beat handshake with RLAST=1 on a busy RID clears busy[RID] and decrements outstanding.
- Outstanding counter width is clog2(MAX_OUT+1).

## Timing
- Reset values: state IDLE, ARVALID=0, ARID=0, ARADDR=0, ARLEN=0, busy=0, outstanding=0, ptr=0, id_err=0, all m_arready=0.
- Latency: request seen in IDLE at cycle 0, ARVALID at cycle 1. m_arready is asserted in the same cycle as the AXI handshake. The earliest issue rate is one AR every 2 cycles.
- R path latency is 0 cycles: valid, ready, data and last pass through combinationally.
- Simultaneous AR handshake and RLAST completion in one cycle: outstanding is net unchanged, and both busy updates apply. A collision on the same master is impossible because the granted master is not busy.
- A completion in IDLE frees capacity the following cycle. At outstanding==MAX_OUT, no grant is made even when requests exist.
- ptr wraps from MASTERS-1 to 0.
- A master dropping m_arvalid while in ADDR is a protocol violation. The arbiter still completes the registered AR.
- Reset mid-burst clears all tracking immediately. Later stale R beats are drained and set id_err.

## Structure
- A shared package holds the state enum {IDLE, ADDR}, the constant AXI_ID_WIDTH=4, and an elaboration check MASTERS<=2**AXI_ID_WIDTH.
- One sub-module, rr_picker: a combinational round-robin priority picker taking req[MASTERS] and ptr, and returning grant index plus a found flag.

## Test plan
- Single request: master 3 requests addr 0x100, len 3, ARREADY=1 → ARVALID in cycle 1 with ARID=3, m_arready[3] pulses once. After 4 beats with RID=3 and RLAST on the 4th, busy[3] returns to 0.
- Round-robin fairness: masters 0, 1 and 8 request continuously with ptr=0 → grant order 0,1,8,0,… as each burst completes.
- MAX_OUT=4 saturation: 6 masters request and no R returns → exactly 4 AR handshakes occur, and ARVALID stays 0 until one RLAST arrives. The 5th AR then follows within 2 cycles.
- Backpressure: ARREADY held low for 5 cycles → ARID, ARADDR and ARLEN are stable throughout, and m_arready stays low until the handshake.
- R steering with stall: interleaved beats RID=2 and RID=5, with m_rready[5]=0 for 2 cycles → RREADY=0 during the stall, no beat is lost, and m_rdata is correct per beat.
- Bad RID and reset: a beat with RID=12, or with a not-busy RID, is drained with RREADY=1 and id_err set. Asserting rst mid-burst zeroes busy, outstanding and ARVALID asynchronously.
